// File: rtl/peri_pwm_capture_pkg.sv
// Shared constants for the PWM capture peripheral: register map, bit positions
// and counter geometry.
package peri_pwm_capture_pkg;

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    localparam logic [3:0] ADR_CTRL     = 4'h0;
    localparam logic [3:0] ADR_STATUS   = 4'h1;
    localparam logic [3:0] ADR_HIGH_L   = 4'h2;
    localparam logic [3:0] ADR_HIGH_H   = 4'h3;
    localparam logic [3:0] ADR_PERIOD_L = 4'h4;
    localparam logic [3:0] ADR_PERIOD_H = 4'h5;

    localparam int unsigned CTRL_EN   = 0;
    localparam int unsigned CTRL_HOLD = 1;
    localparam int unsigned CTRL_CLR  = 7;

    localparam int unsigned STAT_VALID = 0;
    localparam int unsigned STAT_OVF   = 1;
    localparam int unsigned STAT_LEVEL = 2;

endpackage

// File: rtl/peri_pwm_capture_sync.sv
// Multi-flop synchronizer for a single asynchronous input bit.
module sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/peri_pwm_capture.sv
// PWM input capture: measures period and high time between rising edges and
// publishes them as a coherent pair on an 8-bit Wishbone register file.
module peri_pwm_capture
    import peri_pwm_capture_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       wb_we_i,
    input  logic [3:0] wb_adr_i,
    input  logic [7:0] wb_dat_i,
    input  logic       wb_stb_i,
    output logic [7:0] wb_dat_o,
    output logic       wb_ack_o,
    input  logic       pwm_i
);

    localparam logic [CNT_W-1:0] CntOne    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CntPreMax = CNT_MAX - CntOne;

    logic             lvl, prev_q, pwm_edge;
    logic [CNT_W-1:0] pcnt_q, pcnt_d, hcnt_q, hcnt_d;
    logic             armed_q, armed_d;
    logic             en_q, en_d, hold_q, hold_d;
    logic             valid_q, valid_d, ovf_q, ovf_d;
    logic [CNT_W-1:0] high_q, high_d, period_q, period_d;
    logic [23:0]      shadow_q, shadow_d;
    logic             ctrl_wr, clr, rd_high, publish, pcnt_reach;
    logic             unused_dat;

    sync_ff #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i(clk_i),
        .rst_i(rst_i),
        .d_i  (pwm_i),
        .q_o  (lvl)
    );

    assign pwm_edge = lvl & ~prev_q;

    assign ctrl_wr    = wb_stb_i & wb_we_i & (wb_adr_i == ADR_CTRL);
    assign clr        = ctrl_wr & wb_dat_i[CTRL_CLR];
    assign rd_high    = wb_stb_i & ~wb_we_i & (wb_adr_i == ADR_HIGH_L);
    assign unused_dat = ^wb_dat_i[6:2];

    // A period that hits the ceiling is unmeasurable, so it is never published.
    assign publish    = en_q & pwm_edge & armed_q & ~hold_q & (pcnt_q != CNT_MAX);
    assign pcnt_reach = en_q & ~pwm_edge & (pcnt_q == CntPreMax);

    always_comb begin
        pcnt_d  = pcnt_q;
        hcnt_d  = hcnt_q;
        armed_d = armed_q;
        if (!en_q) begin
            pcnt_d  = '0;
            hcnt_d  = '0;
            armed_d = 1'b0;
        end else if (pwm_edge) begin
            pcnt_d  = CntOne;
            hcnt_d  = CntOne;
            armed_d = 1'b1;
        end else begin
            if (pcnt_q != CNT_MAX) pcnt_d = pcnt_q + CntOne;
            if (lvl && (hcnt_q != CNT_MAX)) hcnt_d = hcnt_q + CntOne;
            if (pcnt_reach) armed_d = 1'b0;
        end
    end

    always_comb begin
        en_d     = en_q;
        hold_d   = hold_q;
        high_d   = high_q;
        period_d = period_q;
        shadow_d = shadow_q;
        valid_d  = valid_q;
        ovf_d    = ovf_q;
        if (ctrl_wr) begin
            en_d   = wb_dat_i[CTRL_EN];
            hold_d = wb_dat_i[CTRL_HOLD];
        end
        // Shadow captures the pre-publish pair so a concurrent publish cannot tear it.
        if (rd_high) shadow_d = {high_q[15:8], period_q};
        if (publish) begin
            high_d   = hcnt_q;
            period_d = pcnt_q;
        end
        if (publish) begin
            valid_d = 1'b1;
        end else if (rd_high || clr) begin
            valid_d = 1'b0;
        end
        if (pcnt_reach) begin
            ovf_d = 1'b1;
        end else if (clr) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            prev_q   <= 1'b0;
            pcnt_q   <= '0;
            hcnt_q   <= '0;
            armed_q  <= 1'b0;
            en_q     <= 1'b0;
            hold_q   <= 1'b0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            high_q   <= '0;
            period_q <= '0;
            shadow_q <= '0;
        end else begin
            prev_q   <= lvl;
            pcnt_q   <= pcnt_d;
            hcnt_q   <= hcnt_d;
            armed_q  <= armed_d;
            en_q     <= en_d;
            hold_q   <= hold_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            high_q   <= high_d;
            period_q <= period_d;
            shadow_q <= shadow_d;
        end
    end

    always_comb begin
        wb_dat_o = 8'h00;
        case (wb_adr_i)
            ADR_CTRL:     wb_dat_o = {6'b0, hold_q, en_q};
            ADR_STATUS:   wb_dat_o = {5'b0, lvl, ovf_q, valid_q};
            ADR_HIGH_L:   wb_dat_o = high_q[7:0];
            ADR_HIGH_H:   wb_dat_o = shadow_q[23:16];
            ADR_PERIOD_L: wb_dat_o = shadow_q[7:0];
            ADR_PERIOD_H: wb_dat_o = shadow_q[15:8];
            default:      wb_dat_o = 8'h00;
        endcase
    end

    assign wb_ack_o = wb_stb_i;

endmodule

// File: tb/tb_peri_pwm_capture.sv
// Bench for peri_pwm_capture: table-driven measurements, hand-built corner
// sequences and a randomized run against a cycle-stamp reference model.
module tb_peri_pwm_capture;

    localparam int S = 2;

    logic       clk = 1'b0;
    logic       rst, wb_we, wb_stb, pwm, wb_ack;
    logic [3:0] wb_adr;
    logic [7:0] wb_dat_i, wb_dat_o;

    peri_pwm_capture #(
        .SYNC_STAGES(S)
    ) dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .wb_we_i (wb_we),
        .wb_adr_i(wb_adr),
        .wb_dat_i(wb_dat_i),
        .wb_stb_i(wb_stb),
        .wb_dat_o(wb_dat_o),
        .wb_ack_o(wb_ack),
        .pwm_i   (pwm)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model: the measured quantities are cycle-stamp differences and
    // sums over a history of the synchronized level.
    int unsigned c = 0;
    int unsigned base;
    bit          base_edge, en_m, hold_m, valid_m, ovf_m, lvl_m, prev_m;
    logic [15:0] high_m, period_m;
    logic [23:0] shadow_m;
    bit          dly[$];
    bit          lvl_hist[0:262143];
    bit          pwm_cur = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    function automatic void model_reset();
        base = 0; base_edge = 0; en_m = 0; hold_m = 0; valid_m = 0; ovf_m = 0;
        lvl_m = 0; prev_m = 0; high_m = '0; period_m = '0; shadow_m = '0;
        dly = {};
        for (int i = 0; i < S; i++) dly.push_back(1'b0);
    endfunction

    function automatic logic [7:0] exp_rd(logic [3:0] a);
        case (a)
            4'h0: return {6'b0, hold_m, en_m};
            4'h1: return {5'b0, lvl_m, ovf_m, valid_m};
            4'h2: return high_m[7:0];
            4'h3: return shadow_m[23:16];
            4'h4: return shadow_m[7:0];
            4'h5: return shadow_m[15:8];
            default: return 8'h00;
        endcase
    endfunction

    function automatic void model_tick(bit p, bit stb, bit we, logic [3:0] a, logic [7:0] d);
        bit          edge_now = lvl_m & ~prev_m;
        int unsigned el       = c - base;
        bit          rd2      = stb && !we && (a == 4'h2);
        bit          wr0      = stb && we && (a == 4'h0);
        bit          clr      = wr0 && d[7];
        bit          publish  = en_m && edge_now && base_edge && (el < 65535) && !hold_m;
        bit          ovf_set  = en_m && !edge_now && (el == 65534);
        if (rd2) shadow_m = {high_m[15:8], period_m};
        if (publish) begin
            int unsigned s = 0;
            for (int unsigned i = base; i < c; i++) s += lvl_hist[i];
            high_m   = 16'(s);
            period_m = 16'(el);
        end
        if (publish) valid_m = 1'b1;
        else if (rd2 || clr) valid_m = 1'b0;
        if (ovf_set) ovf_m = 1'b1;
        else if (clr) ovf_m = 1'b0;
        if (en_m && edge_now) begin
            base = c;
            base_edge = 1'b1;
        end
        if (wr0 && d[0] && !en_m) begin
            base = c + 1;
            base_edge = 1'b0;
        end
        if (wr0) begin
            en_m   = d[0];
            hold_m = d[1];
        end
        lvl_hist[c] = lvl_m;
        prev_m = lvl_m;
        dly.push_front(p);
        void'(dly.pop_back());
        lvl_m = dly[S-1];
        c++;
    endfunction

    task automatic cyc(input bit p, input bit stb, input bit we, input logic [3:0] a,
                       input logic [7:0] d, output logic [7:0] rdata);
        @(negedge clk);
        pwm = p; wb_stb = stb; wb_we = we; wb_adr = a; wb_dat_i = d;
        #1;
        if (stb) check("ack", {31'b0, wb_ack}, 32'd1);
        if (stb && !we) check($sformatf("rd_model_a%0h", a), {24'b0, wb_dat_o}, {24'b0, exp_rd(a)});
        rdata = wb_dat_o;
        @(posedge clk);
        model_tick(p, stb, we, a, d);
    endtask

    task automatic idle(input int n);
        logic [7:0] v;
        repeat (n) cyc(pwm_cur, 1'b0, 1'b0, 4'h0, 8'h00, v);
    endtask

    task automatic rd(input logic [3:0] a, output logic [7:0] v);
        cyc(pwm_cur, 1'b1, 1'b0, a, 8'h00, v);
    endtask

    task automatic rd_chk(input string name, input logic [3:0] a, input logic [7:0] exp);
        logic [7:0] v;
        rd(a, v);
        check(name, {24'b0, v}, {24'b0, exp});
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        logic [7:0] v;
        cyc(pwm_cur, 1'b1, 1'b1, a, d, v);
    endtask

    task automatic run_pwm(input int period, input int high, input int nper);
        for (int n = 0; n < nper; n++) begin
            for (int i = 0; i < period; i++) begin
                pwm_cur = (i < high);
                idle(1);
            end
        end
    endtask

    typedef struct {
        int         period;
        int         high;
        logic [7:0] h_l, h_h, p_l, p_h;
    } vec_t;

    vec_t       vecs[5];
    logic [7:0] v;

    initial begin
        vecs[0] = '{10, 3, 8'h03, 8'h00, 8'h0A, 8'h00};
        vecs[1] = '{5, 1, 8'h01, 8'h00, 8'h05, 8'h00};
        vecs[2] = '{2, 1, 8'h01, 8'h00, 8'h02, 8'h00};
        vecs[3] = '{64, 32, 8'h20, 8'h00, 8'h40, 8'h00};
        vecs[4] = '{300, 299, 8'h2B, 8'h01, 8'h2C, 8'h01};

        rst = 1'b1; pwm = 1'b0; wb_stb = 1'b0; wb_we = 1'b0; wb_adr = '0; wb_dat_i = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();

        for (int a = 0; a < 16; a++) rd_chk($sformatf("reset_a%0h", a), 4'(a), 8'h00);

        foreach (vecs[k]) begin
            wr(4'h0, 8'h00);
            wr(4'h0, 8'h01);
            run_pwm(vecs[k].period, vecs[k].high, 5);
            pwm_cur = 1'b0;
            idle(3);
            rd(4'h1, v);
            check($sformatf("vec%0d_valid_before", k), {31'b0, v[0]}, 32'd1);
            rd_chk($sformatf("vec%0d_high_l", k), 4'h2, vecs[k].h_l);
            rd(4'h1, v);
            check($sformatf("vec%0d_valid_after", k), {31'b0, v[0]}, 32'd0);
            rd_chk($sformatf("vec%0d_high_h", k), 4'h3, vecs[k].h_h);
            rd_chk($sformatf("vec%0d_period_l", k), 4'h4, vecs[k].p_l);
            rd_chk($sformatf("vec%0d_period_h", k), 4'h5, vecs[k].p_h);
        end

        // New results land after the 0x2 read; shadow must keep the 300/299 pair.
        run_pwm(100, 40, 3);
        pwm_cur = 1'b0;
        idle(3);
        rd_chk("shadow_high_h", 4'h3, 8'h01);
        rd_chk("shadow_period_l", 4'h4, 8'h2C);
        rd_chk("shadow_period_h", 4'h5, 8'h01);
        rd_chk("live_high_l", 4'h2, 8'h28);

        // Stuck low after activity.
        idle(65560);
        rd(4'h1, v);
        check("stuck_low_status", {24'b0, v & 8'h06}, 32'h2);
        run_pwm(10, 3, 1);
        rd(4'h1, v);
        check("first_edge_after_ovf", {31'b0, v[0]}, 32'd0);
        run_pwm(10, 3, 1);
        pwm_cur = 1'b0;
        idle(3);
        rd(4'h1, v);
        check("second_edge_published", {31'b0, v[0]}, 32'd1);
        rd_chk("second_edge_high", 4'h2, 8'h03);
        wr(4'h0, 8'h81);
        rd(4'h1, v);
        check("ovf_cleared", {31'b0, v[1]}, 32'd0);

        // Stuck high, entered exactly on a period boundary.
        wr(4'h0, 8'h00);
        wr(4'h0, 8'h01);
        run_pwm(10, 3, 2);
        pwm_cur = 1'b1;
        idle(65560);
        rd(4'h1, v);
        check("stuck_high_status", {24'b0, v & 8'h06}, 32'h6);
        rd_chk("stuck_high_high_kept", 4'h2, 8'h03);
        rd_chk("stuck_high_period_kept", 4'h4, 8'h0A);
        pwm_cur = 1'b0;
        idle(3);
        wr(4'h0, 8'h81);

        // HOLD suppresses publishing but edges still arm.
        wr(4'h0, 8'h03);
        run_pwm(20, 7, 3);
        pwm_cur = 1'b0;
        idle(3);
        rd(4'h1, v);
        check("hold_no_valid", {31'b0, v[0]}, 32'd0);
        rd_chk("hold_results_kept", 4'h2, 8'h03);
        wr(4'h0, 8'h01);
        pwm_cur = 1'b1;
        repeat (S) idle(1);
        wr(4'h0, 8'h81);
        rd(4'h1, v);
        check("publish_beats_clear", {31'b0, v[0]}, 32'd1);
        pwm_cur = 1'b0;
        idle(5);
        rd(4'h2, v);
        pwm_cur = 1'b1;
        repeat (S) idle(1);
        rd(4'h2, v);
        rd(4'h1, v);
        check("publish_beats_read", {31'b0, v[0]}, 32'd1);

        // Asynchronous reset in the middle of a clock low phase.
        run_pwm(10, 3, 1);
        run_pwm(10, 3, 1);
        pwm_cur = 1'b1;
        idle(2);
        @(negedge clk);
        wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 4'h2;
        #2 rst = 1'b1;
        #1 check("rst_async_high_l", {24'b0, wb_dat_o}, 32'h0);
        wb_adr = 4'h0;
        #0.5 check("rst_async_ctrl", {24'b0, wb_dat_o}, 32'h0);
        wb_adr = 4'h1;
        #0.5 check("rst_async_status", {24'b0, wb_dat_o}, 32'h0);
        wb_stb = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        pwm_cur = 1'b0;
        idle(2);
        wr(4'h0, 8'h01);
        run_pwm(10, 3, 1);
        rd(4'h1, v);
        check("first_edge_after_reset", {31'b0, v[0]}, 32'd0);
        run_pwm(10, 3, 2);
        pwm_cur = 1'b0;
        idle(3);
        rd_chk("post_reset_publish", 4'h2, 8'h03);

        // Randomized traffic checked against the model on every read.
        wr(4'h0, 8'h01);
        for (int k = 0; k < 150; k++) begin
            int per = $urandom_range(2, 40);
            int hi  = $urandom_range(1, per - 1);
            int np  = $urandom_range(1, 3);
            for (int n = 0; n < np; n++) begin
                for (int i = 0; i < per; i++) begin
                    pwm_cur = (i < hi);
                    if ($urandom_range(0, 3) == 0) begin
                        logic [3:0] a;
                        logic [7:0] d;
                        bit         we;
                        a  = 4'($urandom_range(0, 7));
                        we = ($urandom_range(0, 4) == 0);
                        d  = 8'($urandom);
                        d[0] = ($urandom_range(0, 7) != 0);
                        d[1] = ($urandom_range(0, 7) == 0);
                        d[7] = ($urandom_range(0, 3) == 0);
                        cyc(pwm_cur, 1'b1, we, a, d, v);
                    end else begin
                        idle(1);
                    end
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/peri_pwm_capture.md
# peri_pwm_capture

Wishbone B4 peripheral that measures an external PWM signal, the receive-side counterpart of the PWM output channel. It synchronizes `pwm_i`, detects rising edges, and counts period and high time in clock cycles. It publishes each completed measurement as a coherent pair in byte-wide registers on the same 8-bit peripheral bus. It detects stuck-low and stuck-high inputs by counter saturation.

## Interface
- `SYNC_STAGES`, 2: flip-flops in the `pwm_i` synchronizer (≥2).
- `clk_i  in  1`: single system clock.
- `rst_i  in  1`: reset, asynchronous, active-high.
- `wb_we_i  in  1`: write enable.
- `wb_adr_i  in  4`: register address.
- `wb_dat_i  in  8`: write data.
- `wb_stb_i  in  1`: strobe; a cycle with `wb_stb_i=1` is one transfer.
- `wb_dat_o  out  8`: read data, combinational from `wb_adr_i` and registers.
- `wb_ack_o  out  1`: equals `wb_stb_i`; zero wait states.
- `pwm_i  in  1`: asynchronous PWM input.

## Operation
- Register map; unlisted addresses read 0 and ignore writes:
  - 0x0 CTRL rw: bit0 EN, bit1 HOLD. Writing 1 to bit7 clears VALID and OVF. Bit7 is self-clearing and reads 0.
  - 0x1 STATUS ro: bit0 VALID, bit1 OVF, bit2 LEVEL (synchronized input).
  - 0x2 HIGH[7:0]: reading returns the live result. The same read loads shadow = {HIGH[15:8], PERIOD[15:0]} and clears VALID.
  - 0x3 HIGH[15:8], 0x4 PERIOD[7:0], 0x5 PERIOD[15:8]: return shadow bytes.
- Synchronizer output `lvl`. `prev` is `lvl` delayed one cycle. `edge = lvl & ~prev`.
- Counters are 16-bit and saturate at 0xFFFF:
  - `pcnt`: set to 1 on `edge`, otherwise +1.
  - `hcnt`: set to 1 on `edge`, otherwise + `lvl`.
- At an `edge`, the result is {HIGH = `hcnt`, PERIOD = `pcnt`} as they stand before reload. For a period of N cycles with H high cycles, this yields PERIOD=N and HIGH=H.
- `armed` flag: set on every `edge`; cleared by reset, by EN=0, and by `pcnt` reaching 0xFFFF.
- Publish rule: an `edge` with `armed=1`, HOLD=0 and `pcnt≠0xFFFF` writes HIGH/PERIOD and sets VALID. Any other `edge` only reloads the counters. The first edge after enable or after overflow is therefore never published.
- OVF: sticky. Set when `pcnt` reaches 0xFFFF, which covers a stuck-low or stuck-high input. Cleared only by the CTRL bit7 write or by reset.
- EN=0: counters held at 0, `armed`=0. Results, shadow and flags are retained. The synchronizer keeps running.
- Simultaneous events:
  - Publish and a read of 0x2 in the same cycle: the read and shadow get the old values, and VALID ends at 1.
  - Publish or overflow together with a CTRL clear: the set wins.
  - A CTRL write in the same cycle as an edge: the edge is evaluated with the old EN/HOLD.

## Timing
- Reset values: all registers 0. `wb_dat_o` follows the address, so 0 at every address after reset. `wb_ack_o` = `wb_stb_i`. The synchronizer and `prev` are 0.
- `pwm_i` high sampled at edge k: `edge` is asserted in cycle k+SYNC_STAGES. Results and VALID are visible from cycle k+SYNC_STAGES+1.
- Synchronizer latency is equal on both edges, so it cancels and HIGH/PERIOD are exact.
- Register writes take effect at the clock edge ending the strobe cycle. The read side effects (shadow load, VALID clear) happen at that same edge.
- Reset asserted mid-measurement: immediate clear of everything, with no partial publish.

## Structure
- Package `peri_pwm_capture_pkg` holds:
  - address localparams ADR_CTRL … ADR_PERIOD_H;
  - CTRL/STATUS bit indices;
  - `CNT_W = 16` and `CNT_MAX`.
- Sub-module `sync_ff` (parameter STAGES, async active-high reset) for `pwm_i`, reusable elsewhere.
- Everything else is in one module: counters, publish logic, register file.

## Test plan
- EN=1, `pwm_i` period 10 with high 3, run 4 periods -> read 0x2..0x5 gives 03,00,0A,00. VALID=1 before the 0x2 read and 0 after.
- Period 300 with high 299 -> HIGH=0x012B, PERIOD=0x012C. Shadow stays coherent while a new edge is published between the 0x2 read and the 0x5 read.
- `pwm_i` stuck low for 70000 cycles after activity -> OVF=1 and LEVEL=0. The next edge is not published; the one after it is. A CTRL write of 0x81 clears OVF.
- `pwm_i` stuck high -> OVF=1 and LEVEL=1. HIGH/PERIOD keep their last values.
- HOLD=1 across 3 periods -> no VALID and results unchanged. A publish coinciding with a CTRL bit7 clear -> VALID=1.
- `rst_i` pulsed mid-period (async, between clock edges) -> all registers read 0 immediately. The first post-reset edge is not published.
